// File: rtl/centroid_update.sv
// centroid_update: k-means centroid recompute (floored sum/count) for five clusters via one shared restoring divider
// Ports: clk/rst_n (sync active-low reset); start requests an update, init_en loads init_x/init_y (both IDLE only);
// sum_x/sum_y/count are packed {E,D,C,B,A} inputs; cent_x/cent_y are the current centroids;
// busy spans the update, done pulses one cycle at completion with converged (no centroid moved).
module centroid_update #(
    parameter int SUM_W = 24,
    parameter int CNT_W = 14,
    parameter int CRD_W = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [5*SUM_W-1:0]   sum_x,
    input  logic [5*SUM_W-1:0]   sum_y,
    input  logic [5*CNT_W-1:0]   count,
    input  logic                 init_en,
    input  logic [5*CRD_W-1:0]   init_x,
    input  logic [5*CRD_W-1:0]   init_y,
    output logic [5*CRD_W-1:0]   cent_x,
    output logic [5*CRD_W-1:0]   cent_y,
    output logic                 busy,
    output logic                 done,
    output logic                 converged
);
    localparam int BW = $clog2(SUM_W);
    typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, FIN} state_t;
    state_t             state;
    logic [5*SUM_W-1:0] sx, sy;
    logic [5*CNT_W-1:0] cn;
    logic [SUM_W-1:0]   dvd;
    logic [CNT_W-1:0]   dsr;
    logic [CNT_W:0]     rem;
    logic [BW-1:0]      bit_cnt;
    logic [2:0]         k;
    logic               c;
    logic               moved;
    logic [CNT_W+1:0]   trial;
    logic               neg;
    logic [CNT_W-1:0]   cnt_k;
    logic [CRD_W-1:0]   old_v, new_v;
    logic               last;
    always_comb begin
        // rem < divisor < 2^CNT_W, so the top bit of trial is a reliable sign
        trial = {rem, dvd[SUM_W-1]} - {2'b00, dsr};
        neg   = trial[CNT_W+1];
        cnt_k = cn[k*CNT_W +: CNT_W];
        old_v = c ? cent_y[k*CRD_W +: CRD_W] : cent_x[k*CRD_W +: CRD_W];
        // dvd holds the finished quotient in STORE; zero count keeps the old centroid
        new_v = (cnt_k == '0) ? old_v : (|dvd[SUM_W-1:CRD_W]) ? {CRD_W{1'b1}} : dvd[CRD_W-1:0];
        last  = (k == 3'd4) && c;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sx        <= '0;
            sy        <= '0;
            cn        <= '0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            bit_cnt   <= '0;
            k         <= '0;
            c         <= 1'b0;
            moved     <= 1'b0;
            cent_x    <= '0;
            cent_y    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_en) begin
                        cent_x <= init_x;
                        cent_y <= init_y;
                    end else if (start) begin
                        sx    <= sum_x;
                        sy    <= sum_y;
                        cn    <= count;
                        k     <= '0;
                        c     <= 1'b0;
                        moved <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    dvd     <= c ? sy[k*SUM_W +: SUM_W] : sx[k*SUM_W +: SUM_W];
                    dsr     <= cnt_k;
                    rem     <= '0;
                    bit_cnt <= BW'(SUM_W-1);
                    state   <= DIV;
                end
                DIV: begin
                    // quotient bits shift into dvd as dividend bits shift out
                    rem <= neg ? {rem[CNT_W-1:0], dvd[SUM_W-1]} : trial[CNT_W:0];
                    dvd <= {dvd[SUM_W-2:0], ~neg};
                    if (bit_cnt == '0)
                        state <= STORE;
                    else
                        bit_cnt <= bit_cnt - 1'b1;
                end
                STORE: begin
                    if (c)
                        cent_y[k*CRD_W +: CRD_W] <= new_v;
                    else
                        cent_x[k*CRD_W +: CRD_W] <= new_v;
                    moved <= moved | (new_v != old_v);
                    if (last) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        converged <= ~(moved | (new_v != old_v));
                        state     <= FIN;
                    end else begin
                        c     <= ~c;
                        k     <= c ? k + 3'd1 : k;
                        state <= LOAD;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_centroid_update.sv
// tb_centroid_update: directed checks of centroid_update timing, arithmetic, convergence and reset
module tb_centroid_update;
    localparam int SW = 24, NW = 14, CW = 14;
    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, init_en = 1'b0;
    logic [5*SW-1:0]   sum_x = '0, sum_y = '0;
    logic [5*NW-1:0]   count = '0;
    logic [5*CW-1:0]   init_x = '0, init_y = '0;
    logic [5*CW-1:0]   cent_x, cent_y;
    logic              busy, done, converged;
    int                checks = 0, errors = 0, cyc = 0;
    always #5 clk = ~clk;
    centroid_update #(.SUM_W(SW), .CNT_W(NW), .CRD_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sum_x(sum_x), .sum_y(sum_y),
        .count(count), .init_en(init_en), .init_x(init_x), .init_y(init_y),
        .cent_x(cent_x), .cent_y(cent_y), .busy(busy), .done(done), .converged(converged)
    );
    function automatic logic [5*SW-1:0] ps(input int a, b, c, d, e);
        return {SW'(e), SW'(d), SW'(c), SW'(b), SW'(a)};
    endfunction
    function automatic logic [5*CW-1:0] pc(input int a, b, c, d, e);
        return {CW'(e), CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    // raises start for one cycle (cycle 0); returns #1 into cycle 1
    task automatic go();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
    endtask
    task automatic run_to_done();
        while (done !== 1'b1 && cyc < 400) step();
    endtask
    task automatic load_init(input logic [5*CW-1:0] x, input logic [5*CW-1:0] y);
        init_x = x;
        init_y = y;
        init_en = 1'b1;
        step();
        init_en = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (cent_x !== '0) begin errors++; $display("FAIL reset_cent_x got %h exp 0", cent_x); end
        checks++; if (cent_y !== '0) begin errors++; $display("FAIL reset_cent_y got %h exp 0", cent_y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (converged !== 1'b0) begin errors++; $display("FAIL reset_conv got %b exp 0", converged); end
        rst_n = 1'b1;
        step();
    endtask
    task automatic test_basic();
        load_init(pc(0,0,0,0,0), pc(0,0,0,0,0));
        sum_x = ps(100,0,0,0,0);
        sum_y = ps(40,0,0,0,0);
        count = pc(4,0,0,0,0);
        go();
        sum_x = ps(9,9,9,9,9);
        sum_y = ps(9,9,9,9,9);
        count = pc(1,1,1,1,1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy1 got %b exp 1", busy); end
        while (cyc < 26) step();
        checks++; if (cent_x !== pc(0,0,0,0,0)) begin errors++; $display("FAIL basic_ax_c26 got %h exp %h", cent_x, pc(0,0,0,0,0)); end
        step();
        checks++; if (cent_x !== pc(25,0,0,0,0)) begin errors++; $display("FAIL basic_ax_c27 got %h exp %h", cent_x, pc(25,0,0,0,0)); end
        while (cyc < 260) step();
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL basic_c260 got busy,done=%b exp 10", {busy, done}); end
        step();
        checks++; if ({busy, done, converged} !== 3'b010) begin errors++; $display("FAIL basic_c261 got busy,done,conv=%b exp 010", {busy, done, converged}); end
        checks++; if (cent_x !== pc(25,0,0,0,0)) begin errors++; $display("FAIL basic_cent_x got %h exp %h", cent_x, pc(25,0,0,0,0)); end
        checks++; if (cent_y !== pc(10,0,0,0,0)) begin errors++; $display("FAIL basic_cent_y got %h exp %h", cent_y, pc(10,0,0,0,0)); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    endtask
    task automatic test_trunc_sat_zero();
        load_init(pc(0,0,0,777,0), pc(0,0,0,555,0));
        checks++; if (cent_x !== pc(0,0,0,777,0)) begin errors++; $display("FAIL init_cent_x got %h exp %h", cent_x, pc(0,0,0,777,0)); end
        sum_x = ps(0,10,20000,999,0);
        sum_y = ps(0,7,5,888,0);
        count = pc(0,3,1,0,0);
        go();
        run_to_done();
        checks++; if (cyc !== 261) begin errors++; $display("FAIL trunc_latency got %0d exp 261", cyc); end
        checks++; if (cent_x !== pc(0,3,16383,777,0)) begin errors++; $display("FAIL trunc_cent_x got %h exp %h", cent_x, pc(0,3,16383,777,0)); end
        checks++; if (cent_y !== pc(0,2,5,555,0)) begin errors++; $display("FAIL trunc_cent_y got %h exp %h", cent_y, pc(0,2,5,555,0)); end
        checks++; if (converged !== 1'b0) begin errors++; $display("FAIL trunc_conv got %b exp 0", converged); end
    endtask
    task automatic test_converge();
        sum_x = ps(6,9,32766,777,4);
        sum_y = ps(0,6,10,555,3);
        count = pc(7,3,2,1,5);
        go();
        run_to_done();
        checks++; if (cyc !== 261) begin errors++; $display("FAIL conv_latency got %0d exp 261", cyc); end
        checks++; if (converged !== 1'b1) begin errors++; $display("FAIL conv_flag got %b exp 1", converged); end
        checks++; if (cent_x !== pc(0,3,16383,777,0)) begin errors++; $display("FAIL conv_cent_x got %h exp %h", cent_x, pc(0,3,16383,777,0)); end
        checks++; if (cent_y !== pc(0,2,5,555,0)) begin errors++; $display("FAIL conv_cent_y got %h exp %h", cent_y, pc(0,2,5,555,0)); end
    endtask
    task automatic test_busy();
        sum_x = ps(50,0,0,0,0);
        sum_y = ps(30,0,0,0,0);
        count = pc(2,0,0,0,0);
        go();
        while (cyc < 50) step();
        init_x = pc(1,2,3,4,5);
        init_y = pc(6,7,8,9,10);
        sum_x = ps(1000,1000,1000,1000,1000);
        count = pc(1,1,1,1,1);
        start = 1'b1;
        init_en = 1'b1;
        step();
        start = 1'b0;
        init_en = 1'b0;
        run_to_done();
        checks++; if (cyc !== 261) begin errors++; $display("FAIL busy_latency got %0d exp 261", cyc); end
        checks++; if (cent_x !== pc(25,3,16383,777,0)) begin errors++; $display("FAIL busy_cent_x got %h exp %h", cent_x, pc(25,3,16383,777,0)); end
        checks++; if (cent_y !== pc(15,2,5,555,0)) begin errors++; $display("FAIL busy_cent_y got %h exp %h", cent_y, pc(15,2,5,555,0)); end
        checks++; if (converged !== 1'b0) begin errors++; $display("FAIL busy_conv got %b exp 0", converged); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_requeue got %b exp 0", busy); end
    endtask
    task automatic test_mid_reset();
        sum_x = ps(5,0,0,0,0);
        sum_y = ps(6,0,0,0,0);
        count = pc(1,0,0,0,0);
        go();
        while (cyc < 100) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if ({cent_x, cent_y} !== '0) begin errors++; $display("FAIL mreset_cent got %h exp 0", {cent_x, cent_y}); end
        checks++; if ({busy, done, converged} !== 3'b000) begin errors++; $display("FAIL mreset_flags got %b exp 000", {busy, done, converged}); end
        go();
        run_to_done();
        checks++; if (cyc !== 261) begin errors++; $display("FAIL mreset_latency got %0d exp 261", cyc); end
        checks++; if (cent_x !== pc(5,0,0,0,0)) begin errors++; $display("FAIL mreset_cent_x got %h exp %h", cent_x, pc(5,0,0,0,0)); end
        checks++; if (cent_y !== pc(6,0,0,0,0)) begin errors++; $display("FAIL mreset_cent_y got %h exp %h", cent_y, pc(6,0,0,0,0)); end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_trunc_sat_zero();
        test_converge();
        test_busy();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
